// File: rtl/modexp_seq.sv
// modexp_seq: Montgomery-ladder sequencer driving the paired A / X_tilde multipliers.
// Issues one op per ladder step, gathers both lane dones, and pulses register write enables.
module modexp_seq #(
    parameter int EXP_W = 1024,
    parameter int CNT_W = $clog2(EXP_W)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [EXP_W-1:0] exp,
    input  logic [CNT_W:0]   exp_len,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             mm_start,
    output logic [2:0]       op,
    input  logic             mm_done_a,
    input  logic             mm_done_x,
    output logic             a_we,
    output logic             x_we,
    output logic [31:0]      cycles
);

    localparam logic [2:0] OP_INIT  = 3'd1;
    localparam logic [2:0] OP_BIT1  = 3'd3;
    localparam logic [2:0] OP_BIT0  = 3'd5;
    localparam logic [2:0] OP_FINAL = 3'd7;

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, COMMIT, DONE} state_t;

    state_t           state_q;
    logic [EXP_W-1:0] exp_q;
    logic [CNT_W-1:0] idx_q;
    logic [2:0]       op_q;
    logic             busy_q, done_q, err_q, mm_start_q, a_we_q, x_we_q;
    logic             flag_a_q, flag_x_q;
    logic [31:0]      cycles_q;

    logic             need_a_d, need_x_d, flag_a_d, flag_x_d, go_d, len_ok_d;
    logic [CNT_W-1:0] idx_dec_d;
    logic [2:0]       nxt_op_d;
    logic [31:0]      cycles_d;

    always_comb begin
        need_a_d  = op_q != OP_INIT;
        need_x_d  = op_q != OP_FINAL;
        flag_a_d  = flag_a_q | mm_done_a;
        flag_x_d  = flag_x_q | mm_done_x;
        go_d      = (!need_a_d || flag_a_d) && (!need_x_d || flag_x_d);
        len_ok_d  = (exp_len != '0) && (exp_len <= (CNT_W+1)'(EXP_W));
        idx_dec_d = idx_q - CNT_W'(1);
        // After INIT the current index selects the first ladder bit; afterwards the next-lower bit.
        nxt_op_d  = (op_q == OP_INIT) ? (exp_q[idx_q] ? OP_BIT1 : OP_BIT0) :
                    (idx_q != '0)     ? (exp_q[idx_dec_d] ? OP_BIT1 : OP_BIT0) : OP_FINAL;
        cycles_d  = busy_q ? (&cycles_q ? cycles_q : cycles_q + 32'd1) : cycles_q;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            exp_q      <= '0;
            idx_q      <= '0;
            op_q       <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            mm_start_q <= 1'b0;
            a_we_q     <= 1'b0;
            x_we_q     <= 1'b0;
            flag_a_q   <= 1'b0;
            flag_x_q   <= 1'b0;
            cycles_q   <= '0;
        end else begin
            cycles_q <= cycles_d;
            case (state_q)
                IDLE: if (start) begin
                    cycles_q <= '0;
                    busy_q   <= 1'b1;
                    if (len_ok_d) begin
                        exp_q      <= exp;
                        idx_q      <= CNT_W'(exp_len - 1'b1);
                        op_q       <= OP_INIT;
                        err_q      <= 1'b0;
                        mm_start_q <= 1'b1;
                        state_q    <= ISSUE;
                    end else begin
                        err_q   <= 1'b1;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                ISSUE: begin
                    mm_start_q <= 1'b0;
                    flag_a_q   <= 1'b0;
                    flag_x_q   <= 1'b0;
                    state_q    <= WAIT;
                end
                WAIT: begin
                    flag_a_q <= flag_a_d;
                    flag_x_q <= flag_x_d;
                    if (go_d) begin
                        a_we_q  <= need_a_d;
                        x_we_q  <= need_x_d;
                        state_q <= COMMIT;
                    end
                end
                COMMIT: begin
                    a_we_q <= 1'b0;
                    x_we_q <= 1'b0;
                    if (op_q == OP_FINAL) begin
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        op_q       <= nxt_op_d;
                        mm_start_q <= 1'b1;
                        state_q    <= ISSUE;
                        if (op_q != OP_INIT && idx_q != '0)
                            idx_q <= idx_dec_d;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;
    assign mm_start = mm_start_q;
    assign op       = op_q;
    assign a_we     = a_we_q;
    assign x_we     = x_we_q;
    assign cycles   = cycles_q;

endmodule

// File: tb/tb_modexp_seq.sv
// tb_modexp_seq: scoreboard bench for modexp_seq with latency-configurable stub multipliers.
module tb_modexp_seq;

    typedef struct {int op; int dur; bit a; bit x;} op_exp_t;
    typedef struct {int cyc; bit err; int cycles; int na; int nx;} done_exp_t;

    logic          clk = 1'b0;
    logic          resetn, start;
    logic [1023:0] exp_v;
    logic [10:0]   exp_len;
    logic          busy, done, err, mm_start, mm_done_a, mm_done_x, a_we, x_we;
    logic [2:0]    op;
    logic [31:0]   cycles;

    int tests = 0, fails = 0;
    int cyc = 0, done_cnt = 0, ms_cnt = 0;
    int ca = 0, cx = 0, da = 3, dx = 3;
    op_exp_t   opq[$];
    done_exp_t dq[$];
    op_exp_t   cur;
    done_exp_t dcur;
    bit cur_ok = 0, pend = 0;
    int pend_cyc = 0, iss = 0, na = 0, nx = 0;

    modexp_seq dut (
        .clk(clk), .resetn(resetn), .start(start), .exp(exp_v), .exp_len(exp_len),
        .busy(busy), .done(done), .err(err), .mm_start(mm_start), .op(op),
        .mm_done_a(mm_done_a), .mm_done_x(mm_done_x), .a_we(a_we), .x_we(x_we),
        .cycles(cycles)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Stub lanes: done pulses exactly da/dx cycles after mm_start.
    always @(posedge clk) begin
        if (mm_start) begin
            ca <= da;
            cx <= dx;
        end else begin
            if (ca > 0) ca <= ca - 1;
            if (cx > 0) cx <= cx - 1;
        end
    end
    assign mm_done_a = (ca == 1);
    assign mm_done_x = (cx == 1);

    function automatic void chk(bit ok, string nm, longint act, longint req);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, req, $time);
        end
    endfunction

    // Monitor: pops expectations whenever the DUT presents an event.
    always @(negedge clk) if (resetn) begin
        if (pend) begin
            chk(cycles == pend_cyc, "cycles_final", cycles, pend_cyc);
            chk(!busy, "busy_fall", busy, 0);
            pend = 0;
        end
        if (mm_start) begin
            ms_cnt++;
            if (opq.size() == 0) chk(0, "extra_mm_start", 1, 0);
            else begin
                cur = opq.pop_front();
                cur_ok = 1;
                iss = cyc;
                chk(op == cur.op, "op", op, cur.op);
                chk(!err, "err_clear", err, 0);
            end
        end
        if (a_we || x_we) begin
            if (!cur_ok) chk(0, "stray_we", {a_we, x_we}, 0);
            else begin
                chk(a_we == cur.a, "a_we", a_we, cur.a);
                chk(x_we == cur.x, "x_we", x_we, cur.x);
                chk(cyc - iss == cur.dur - 1, "commit_time", cyc - iss, cur.dur - 1);
                na += int'(a_we);
                nx += int'(x_we);
                cur_ok = 0;
            end
        end
        if (done) begin
            if (dq.size() == 0) chk(0, "extra_done", 1, 0);
            else begin
                dcur = dq.pop_front();
                chk(cyc == dcur.cyc, "done_time", cyc, dcur.cyc);
                chk(err == dcur.err, "err", err, dcur.err);
                chk(busy, "busy_at_done", busy, 1);
                chk(na == dcur.na, "a_we_count", na, dcur.na);
                chk(nx == dcur.nx, "x_we_count", nx, dcur.nx);
                pend = 1;
                pend_cyc = dcur.cycles;
            end
            na = 0;
            nx = 0;
            done_cnt++;
        end
    end

    task automatic launch(input logic [1023:0] e, input int len, input int da_i, input int dx_i,
                          output int dcyc);
        int ops[$];
        int sum, d;
        op_exp_t o;
        done_exp_t de;
        da = da_i;
        dx = dx_i;
        @(negedge clk);
        if (len < 1 || len > 1024) begin
            de = '{cyc: cyc + 1, err: 1, cycles: 1, na: 0, nx: 0};
        end else begin
            ops.push_back(1);
            for (int i = len - 1; i >= 0; i--) ops.push_back(e[i] ? 3 : 5);
            ops.push_back(7);
            sum = 0;
            foreach (ops[i]) begin
                d = 0;
                if (ops[i] != 1 && da_i > d) d = da_i;
                if (ops[i] != 7 && dx_i > d) d = dx_i;
                o = '{op: ops[i], dur: d + 2, a: ops[i] != 1, x: ops[i] != 7};
                opq.push_back(o);
                sum += d + 2;
            end
            de = '{cyc: cyc + 1 + sum, err: 0, cycles: sum + 1, na: len + 1, nx: len + 1};
        end
        dq.push_back(de);
        dcyc = de.cyc;
        start = 1'b1;
        exp_v = e;
        exp_len = 11'(len);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int n0);
        int k = 0;
        while (done_cnt == n0 && k < 10000) begin
            @(negedge clk);
            k++;
        end
        chk(done_cnt != n0, "done_timeout", done_cnt - n0, 1);
        repeat (4) @(negedge clk);
        chk(opq.size() == 0, "ops_left", opq.size(), 0);
    endtask

    task automatic run(input logic [1023:0] e, input int len, input int da_i, input int dx_i);
        int n0, dc;
        n0 = done_cnt;
        launch(e, len, da_i, dx_i, dc);
        wait_done(n0);
    endtask

    initial begin
        logic [1023:0] e;
        int n0, dc, m0, k;
        resetn = 1'b0;
        start = 1'b0;
        exp_v = '0;
        exp_len = '0;
        repeat (2) @(negedge clk);
        chk({busy, done, err, mm_start, a_we, x_we} == 6'b0, "reset_flags", {busy, done, err, mm_start, a_we, x_we}, 0);
        chk(op == 3'd0, "reset_op", op, 0);
        chk(cycles == 32'd0, "reset_cycles", cycles, 0);
        resetn = 1'b1;
        repeat (2) @(negedge clk);

        run(1024'b1011, 4, 3, 3);
        chk(!err, "err_after_run", err, 0);
        run(1024'b1011, 4, 2, 5);
        run(1024'b10, 2, 3, 3);
        run(1024'b0, 1, 1, 3);

        run(1024'b1011, 0, 3, 3);
        chk(err, "err_sticky_len0", err, 1);
        run(1024'b1011, 1025, 3, 3);
        chk(err, "err_sticky_len1025", err, 1);
        run(1024'b0, 1, 3, 3);
        chk(!err, "err_cleared", err, 0);
        run(1024'b1, 1, 3, 3);

        // Start pulses while busy and during the DONE cycle must be ignored.
        n0 = done_cnt;
        launch(1024'b1011, 4, 3, 3, dc);
        repeat (5) @(negedge clk);
        start = 1'b1;
        exp_len = 11'd0;
        @(negedge clk);
        start = 1'b0;
        while (cyc < dc) @(negedge clk);
        start = 1'b1;
        exp_len = 11'd0;
        @(negedge clk);
        start = 1'b0;
        wait_done(n0);

        // Asynchronous reset in the WAIT of the third op.
        m0 = ms_cnt;
        launch(1024'b1011, 4, 3, 3, dc);
        k = 0;
        while (ms_cnt < m0 + 3 && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk(ms_cnt >= m0 + 3, "third_issue", ms_cnt - m0, 3);
        @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        chk({busy, done, err, mm_start, a_we, x_we} == 6'b0, "midrun_reset_flags", {busy, done, err, mm_start, a_we, x_we}, 0);
        chk(op == 3'd0, "midrun_reset_op", op, 0);
        chk(cycles == 32'd0, "midrun_reset_cycles", cycles, 0);
        opq.delete();
        dq.delete();
        cur_ok = 0;
        pend = 0;
        na = 0;
        nx = 0;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        repeat (6) @(negedge clk);
        chk(!busy, "idle_after_reset", busy, 0);
        run(1024'b1011, 4, 3, 3);

        for (int i = 0; i < 32; i++) e[i*32 +: 32] = $urandom;
        run(e, 1024, 3, 3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
